// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the timekeeping path.
// Hour/minute increments are per-digit BCD so no field ever passes through binary.
package clock_pkg;

  typedef struct packed {
    logic [1:0] h_t;
    logic [3:0] h_u;
    logic [2:0] m_t;
    logic [3:0] m_u;
    logic [2:0] s_t;
    logic [3:0] s_u;
  } bcd_time_t;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] u;
  } bcd_hour_t;

  // Minutes and seconds share this shape.
  typedef struct packed {
    logic [2:0] t;
    logic [3:0] u;
  } bcd_min_t;

  typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} mode_t;
  typedef enum logic {IDLE, RINGING} ring_t;

  localparam logic [1:0] HourMaxT = 2'd2;
  localparam logic [3:0] HourMaxU = 4'd3;
  localparam logic [2:0] MinMaxT  = 3'd5;
  localparam logic [3:0] MinMaxU  = 4'd9;

  function automatic bcd_hour_t inc_hour(bcd_hour_t h);
    bcd_hour_t r;
    if (h.t == HourMaxT && h.u == HourMaxU) begin
      r = '0;
    end else if (h.u == 4'd9) begin
      r.t = h.t + 2'd1;
      r.u = 4'd0;
    end else begin
      r.t = h.t;
      r.u = h.u + 4'd1;
    end
    return r;
  endfunction

  function automatic logic min_at_max(bcd_min_t m);
    return (m.t == MinMaxT) && (m.u == MinMaxU);
  endfunction

  function automatic bcd_min_t inc_min(bcd_min_t m);
    bcd_min_t r;
    if (m.u == 4'd9) begin
      r.u = 4'd0;
      r.t = (m.t == MinMaxT) ? 3'd0 : m.t + 3'd1;
    end else begin
      r.t = m.t;
      r.u = m.u + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second tick prescaler: tick pulses for one cycle when the count hits CLK_FREQ_HZ-1.
// clr holds the count at zero so a full period follows its release.
module tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ_HZ - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    tick    = !clr && (count_q == CntMax);
    count_d = (clr || tick) ? '0 : count_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/time_core.sv
// Timekeeping core: 24 h BCD clock, alarm register, display select and alarm ring control.
// disp_time and alarm are registered from next-state so both show a tick's effect together.
module time_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned ALARM_DURATION_S = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_time,
  input  logic        set_alarm,
  input  logic        btn_hour,
  input  logic        btn_min,
  input  logic        alarm_en,
  input  logic        alarm_stop,
  output logic [19:0] disp_time,
  output logic        alarm
);

  localparam int unsigned RingW = (ALARM_DURATION_S >= 1) ? $clog2(ALARM_DURATION_S + 1) : 1;
  localparam logic [RingW-1:0] RingDur = RingW'(ALARM_DURATION_S);

  mode_t            mode_q, mode_d;
  ring_t            ring_q, ring_d;
  bcd_time_t        time_q, time_d, disp_q, disp_d;
  bcd_hour_t        alarm_h_q, alarm_h_d, time_h_inc, alarm_h_inc;
  bcd_min_t         alarm_m_q, alarm_m_d, time_m_inc, time_s_inc, alarm_m_inc;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic             tick, tick_clr, trigger, ring_kill;

  assign tick_clr = (mode_q == SET_TIME);

  tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign time_h_inc  = inc_hour(bcd_hour_t'({time_q.h_t, time_q.h_u}));
  assign time_m_inc  = inc_min(bcd_min_t'({time_q.m_t, time_q.m_u}));
  assign time_s_inc  = inc_min(bcd_min_t'({time_q.s_t, time_q.s_u}));
  assign alarm_h_inc = inc_hour(alarm_h_q);
  assign alarm_m_inc = inc_min(alarm_m_q);

  always_comb begin
    if (set_time) begin
      mode_d = SET_TIME;
    end else if (set_alarm) begin
      mode_d = SET_ALARM;
    end else begin
      mode_d = RUN;
    end
  end

  always_comb begin
    time_d    = time_q;
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;
    unique case (mode_q)
      SET_TIME: begin
        time_d.s_t = 3'd0;
        time_d.s_u = 4'd0;
        if (btn_hour) {time_d.h_t, time_d.h_u} = time_h_inc;
        if (btn_min)  {time_d.m_t, time_d.m_u} = time_m_inc;
      end
      RUN, SET_ALARM: begin
        if (tick) begin
          {time_d.s_t, time_d.s_u} = time_s_inc;
          if (min_at_max(bcd_min_t'({time_q.s_t, time_q.s_u}))) begin
            {time_d.m_t, time_d.m_u} = time_m_inc;
            if (min_at_max(bcd_min_t'({time_q.m_t, time_q.m_u}))) begin
              {time_d.h_t, time_d.h_u} = time_h_inc;
            end
          end
        end
        if (mode_q == SET_ALARM) begin
          if (btn_hour) alarm_h_d = alarm_h_inc;
          if (btn_min)  alarm_m_d = alarm_m_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (mode_d == SET_ALARM) begin
      disp_d = '{h_t: alarm_h_d.t, h_u: alarm_h_d.u, m_t: alarm_m_d.t, m_u: alarm_m_d.u,
                 s_t: 3'd0, s_u: 4'd0};
    end else begin
      disp_d = time_d;
    end
  end

  // Trigger looks at the post-tick time so alarm rises with the matching display.
  always_comb begin
    trigger   = tick && (mode_q != SET_TIME) && alarm_en &&
                (time_d.s_t == 3'd0) && (time_d.s_u == 4'd0) &&
                ({time_d.h_t, time_d.h_u} == alarm_h_q) &&
                ({time_d.m_t, time_d.m_u} == alarm_m_q);
    ring_kill = alarm_stop || !alarm_en || (mode_d == SET_TIME);
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    unique case (ring_q)
      IDLE: begin
        if (trigger && !ring_kill) begin
          ring_d     = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (ring_kill) begin
          ring_d = IDLE;
        end else if (tick) begin
          ring_cnt_d = ring_cnt_q + RingW'(1);
          if (ring_cnt_d == RingDur) ring_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= RUN;
      ring_q     <= IDLE;
      time_q     <= '0;
      alarm_h_q  <= '0;
      alarm_m_q  <= '0;
      disp_q     <= '0;
      ring_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      ring_q     <= ring_d;
      time_q     <= time_d;
      alarm_h_q  <= alarm_h_d;
      alarm_m_q  <= alarm_m_d;
      disp_q     <= disp_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign disp_time = disp_q;
  assign alarm     = (ring_q == RINGING);

endmodule

// File: tb/tb_time_core.sv
// Bench for time_core: vector table, directed alarm/wrap/reset sequences and a random run
// checked every cycle against a seconds-of-day reference model.
module tb_time_core;

  localparam int Freq = 4;
  localparam int Dur  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_time = 1'b0, set_alarm = 1'b0, btn_hour = 1'b0, btn_min = 1'b0;
  logic        alarm_en = 1'b0, alarm_stop = 1'b0;
  logic [19:0] disp_time;
  logic        alarm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  time_core #(
    .CLK_FREQ_HZ     (Freq),
    .ALARM_DURATION_S(Dur)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_time  (set_time),
    .set_alarm (set_alarm),
    .btn_hour  (btn_hour),
    .btn_min   (btn_min),
    .alarm_en  (alarm_en),
    .alarm_stop(alarm_stop),
    .disp_time (disp_time),
    .alarm     (alarm)
  );

  function automatic logic [19:0] pack(int h, int m, int s);
    logic [19:0] r;
    r        = '0;
    r[19:18] = 2'(h / 10);
    r[17:14] = 4'(h % 10);
    r[13:11] = 3'(m / 10);
    r[10:7]  = 4'(m % 10);
    r[6:4]   = 3'(s / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic logic [19:0] pack_secs(int t);
    return pack(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  task automatic check(string name, logic [19:0] act, logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarm as minutes of day, modes 0=run 1=set 2=alarm.
  typedef struct {
    int secs;
    int amin;
    int presc;
    int mode;
    int disp;
    int ring;
    int rcnt;
  } mstate_t;

  function automatic mstate_t model_next(mstate_t s, logic rst, logic st, logic sa, logic bh,
                                         logic bm, logic en, logic stop);
    mstate_t n;
    int h, m, nm;
    bit tick;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    nm      = st ? 1 : (sa ? 2 : 0);
    tick    = (s.mode != 1) && (s.presc == Freq - 1);
    n.presc = (s.mode == 1) ? 0 : (s.presc + 1) % Freq;
    if (s.mode == 1) begin
      h = s.secs / 3600;
      m = (s.secs / 60) % 60;
      if (bh) h = (h + 1) % 24;
      if (bm) m = (m + 1) % 60;
      n.secs = h * 3600 + m * 60;
    end else if (tick) begin
      n.secs = (s.secs + 1) % 86400;
    end
    if (s.mode == 2) begin
      h = s.amin / 60;
      m = s.amin % 60;
      if (bh) h = (h + 1) % 24;
      if (bm) m = (m + 1) % 60;
      n.amin = h * 60 + m;
    end
    n.mode = nm;
    n.disp = (nm == 2) ? n.amin * 60 : n.secs;
    if (s.ring == 0) begin
      if (tick && s.mode != 1 && n.secs % 60 == 0 && n.secs / 60 == s.amin && en && !stop &&
          nm != 1) begin
        n.ring = 1;
        n.rcnt = 0;
      end
    end else if (stop || !en || nm == 1) begin
      n.ring = 0;
    end else if (tick) begin
      n.rcnt = s.rcnt + 1;
      if (n.rcnt == Dur) n.ring = 0;
    end
    return n;
  endfunction

  mstate_t ms = '{default: 0};
  bit      model_on = 1'b0;

  always @(posedge clk) begin
    ms <= model_next(ms, reset, set_time, set_alarm, btn_hour, btn_min, alarm_en, alarm_stop);
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_disp", disp_time, pack_secs(ms.disp));
      check("model_alarm", {19'b0, alarm}, 20'(ms.ring));
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    set_time   = 1'b0;
    set_alarm  = 1'b0;
    btn_hour   = 1'b0;
    btn_min    = 1'b0;
    alarm_en   = 1'b0;
    alarm_stop = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic press(input bit hour, input int n);
    repeat (n) begin
      if (hour) btn_hour = 1'b1;
      else btn_min = 1'b1;
      step(1);
      btn_hour = 1'b0;
      btn_min  = 1'b0;
    end
  endtask

  // Expects hours and minutes at zero on entry; leaves the prescaler freshly released.
  task automatic set_clock(int h, int m);
    set_time = 1'b1;
    step(1);
    press(1'b1, h);
    press(1'b0, m);
    set_time = 1'b0;
    step(1);
  endtask

  task automatic set_alarm_time(int h, int m);
    set_alarm = 1'b1;
    step(1);
    press(1'b1, h);
    press(1'b0, m);
    set_alarm = 1'b0;
    step(1);
  endtask

  // Leaves the DUT one edge before the tick that makes 07:30:00 with alarm 07:30 armed.
  task automatic arm_to_trigger();
    do_reset();
    set_alarm_time(7, 30);
    set_clock(7, 29);
    alarm_en = 1'b1;
    step(4 * 59);
    check("pre_trigger_time", disp_time, pack(7, 29, 59));
    step(3);
    check("pre_trigger_alarm", {19'b0, alarm}, 20'd0);
  endtask

  typedef struct {
    logic        st, sa, bh, bm;
    int          reps;
    logic [19:0] exp_disp;
    string       name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  pack(0, 0, 0),   "enter_set_time"};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9,  pack(9, 0, 0),   "hour_x9"};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 59, pack(9, 59, 0),  "min_x59"};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  pack(9, 0, 0),   "min_wrap_no_carry"};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1,  pack(10, 1, 0),  "both_buttons"};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, pack(10, 1, 0),  "set_time_no_tick"};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  pack(11, 1, 0),  "set_time_priority"};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  pack(0, 0, 0),   "alarm_untouched"};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7,  pack(7, 0, 0),   "alarm_hour_x7"};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 30, pack(7, 30, 0),  "alarm_min_x30"};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  pack(11, 1, 9),  "time_ran_in_set_alarm"};

    step(2);
    reset    = 1'b0;
    model_on = 1'b1;
    check("reset_disp", disp_time, 20'h0);
    check("reset_alarm", {19'b0, alarm}, 20'd0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_time  = vecs[i].st;
      set_alarm = vecs[i].sa;
      btn_hour  = vecs[i].bh;
      btn_min   = vecs[i].bm;
      step(vecs[i].reps);
      check(vecs[i].name, disp_time, vecs[i].exp_disp);
      check({vecs[i].name, "_alarm"}, {19'b0, alarm}, 20'd0);
    end
    clear_inputs();

    // Midnight wrap.
    do_reset();
    set_clock(23, 59);
    step(4 * 59);
    check("wrap_pre", disp_time, pack(23, 59, 59));
    step(3);
    check("wrap_hold", disp_time, pack(23, 59, 59));
    step(1);
    check("wrap_zero", disp_time, 20'h0);

    // Trigger then self-clear after Dur ticks.
    arm_to_trigger();
    step(1);
    check("trigger_disp", disp_time, pack(7, 30, 0));
    check("trigger_alarm", {19'b0, alarm}, 20'd1);
    step(4 * Dur - 1);
    check("ring_hold", {19'b0, alarm}, 20'd1);
    step(1);
    check("ring_timeout", {19'b0, alarm}, 20'd0);

    arm_to_trigger();
    step(1);
    alarm_stop = 1'b1;
    step(1);
    alarm_stop = 1'b0;
    check("stop_clears", {19'b0, alarm}, 20'd0);

    arm_to_trigger();
    alarm_stop = 1'b1;
    step(1);
    alarm_stop = 1'b0;
    check("stop_coincident_alarm", {19'b0, alarm}, 20'd0);
    check("stop_coincident_disp", disp_time, pack(7, 30, 0));
    step(12);
    check("stop_coincident_later", {19'b0, alarm}, 20'd0);

    arm_to_trigger();
    step(1);
    alarm_en = 1'b0;
    step(1);
    check("disable_clears", {19'b0, alarm}, 20'd0);

    arm_to_trigger();
    step(1);
    set_time = 1'b1;
    step(1);
    set_time = 1'b0;
    check("set_time_clears", {19'b0, alarm}, 20'd0);

    // Reset while ringing.
    arm_to_trigger();
    step(1);
    check("ring_before_reset", {19'b0, alarm}, 20'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("reset_ring_disp", disp_time, 20'h0);
    check("reset_ring_alarm", {19'b0, alarm}, 20'd0);
    alarm_en = 1'b1;
    step(3);
    check("reset_presc_hold", disp_time, 20'h0);
    step(1);
    check("reset_presc_tick", disp_time, pack(0, 0, 1));
    step(4 * 300);
    check("no_early_trigger", {19'b0, alarm}, 20'd0);

    // Random run, checked per cycle by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      set_time   = ($urandom_range(0, 99) < 3);
      set_alarm  = ($urandom_range(0, 99) < 10);
      btn_hour   = ($urandom_range(0, 99) < 25);
      btn_min    = ($urandom_range(0, 99) < 25);
      alarm_en   = ($urandom_range(0, 99) < 90);
      alarm_stop = ($urandom_range(0, 99) < 2);
      step(1);
    end
    clear_inputs();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_core.md
Name: time_core

Overview:
- Timekeeping stage directly upstream of the display block.
- Generates the 1 Hz tick and keeps 24 h BCD time, holds the alarm time, and compares the two to raise the alarm.
- Selects which time is shown on the display.
- Drives disp_time[19:0] and alarm; 12/24 h conversion and LED effects stay downstream.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clock cycles per 1 s tick
- ALARM_DURATION_S, 60, ticks the alarm rings before self-clearing

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- set_time  in  1  switch: time-setting mode
- set_alarm  in  1  switch: alarm-setting mode
- btn_hour  in  1  one-cycle pulse (debounced upstream): increment hours
- btn_min  in  1  one-cycle pulse (debounced upstream): increment minutes
- alarm_en  in  1  alarm armed
- alarm_stop  in  1  one-cycle pulse: silence the ringing alarm
- disp_time  out  20  packed BCD HH:MM:SS, registered
- alarm  out  1  alarm trigger, registered

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- disp_time packing:
  - [19:18] hour tens, [17:14] hour units
  - [13:11] min tens, [10:7] min units
  - [6:4] sec tens, [3:0] sec units
  - 24 h format
- Reset values:
  - time 00:00:00, alarm time 00:00, prescaler 0
  - disp_time = 20'h0, alarm = 0
  - mode FSM = RUN, ring FSM = IDLE
- Tick generator:
  - Counts 0..CLK_FREQ_HZ-1.
  - tick is a 1-cycle pulse in the cycle where count == CLK_FREQ_HZ-1, then count wraps to 0.
- Mode FSM (RUN, SET_TIME, SET_ALARM):
  - Next state is decoded each cycle from the switches.
  - set_time=1 gives SET_TIME, regardless of set_alarm.
  - Otherwise set_alarm=1 gives SET_ALARM; else RUN.
- RUN:
  - On tick, seconds increment with BCD carries: sec 59 -> 00 carries into min; min 59 -> 00 carries into hour; 23:59:59 -> 00:00:00.
  - btn_hour and btn_min are ignored.
- SET_TIME:
  - Prescaler is held at 0 and seconds are forced to 00.
  - btn_hour: hour +1, 23 -> 00.
  - btn_min: minute +1, 59 -> 00, with no carry into hour.
  - Both pulses in the same cycle apply both increments.
  - On leaving SET_TIME, counting restarts from a full tick period.
- SET_ALARM:
  - Time keeps running as in RUN.
  - Buttons edit the alarm time with the same wrap rules.
- disp_time source:
  - RUN and SET_TIME: current time.
  - SET_ALARM: alarm time with seconds 00.
  - Registered: the value reflects a tick or button one cycle later.
- Ring FSM (IDLE, RINGING):
  - IDLE -> RINGING when a RUN or SET_ALARM tick produces a time with HH:MM == alarm HH:MM, seconds == 00, and alarm_en=1.
  - alarm rises in the same cycle disp_time first shows the matching time.
  - A time made equal by SET_TIME edits never triggers; only a tick does.
  - RINGING -> IDLE when any of the following holds:
    - alarm_stop=1
    - alarm_en=0
    - entering SET_TIME
    - the ring counter reaches ALARM_DURATION_S ticks
  - alarm deasserts on the next cycle.
  - alarm_stop in the same cycle as a trigger: stop wins, and alarm stays 0.
  - The ring counter is cleared on entry to RINGING and counts ticks only.
- Reset mid-operation: everything returns to its reset value on the next edge, including ringing and the prescaler.
- Arithmetic is per-digit BCD. No binary intermediate that is wider than the field.

Decomposition:
- Shared package clock_pkg:
  - typedef bcd_time_t: packed struct with h_t[1:0], h_u[3:0], m_t[2:0], m_u[3:0], s_t[2:0], s_u[3:0] (20 bits).
  - Enums mode_t {RUN, SET_TIME, SET_ALARM} and ring_t {IDLE, RINGING}.
  - Constants for BCD limits (23, 59).
  - Increment functions inc_hour and inc_min, shared by the time and alarm paths.
- Sub-module tick_gen (param CLK_FREQ_HZ; ports clk, reset, clr, tick), instantiated once.

Test Plan:
- CLK_FREQ_HZ=4, set time 23:59, release to RUN, run 60 ticks -> disp_time reads 20'h0 (00:00:00) exactly one cycle after the wrap tick.
- SET_TIME at 09:59: btn_min ×1 -> 09:00 (no hour carry); btn_hour and btn_min in the same cycle -> 10:01; seconds stay 00 and the prescaler stays idle.
- Alarm 07:30, alarm_en=1, time 07:29:59, one tick -> disp_time 07:30:00 and alarm=1 in the same cycle; with ALARM_DURATION_S=3, alarm drops after 3 more ticks.
- Ringing, then alarm_stop pulse -> alarm=0 next cycle; repeat with alarm_stop coincident with the trigger tick -> alarm never rises.
- set_alarm=1 and set_time=1 together -> SET_TIME behaviour; buttons edit the time, and the alarm register is unchanged.
- reset asserted while RINGING at 12:34:56 -> next cycle disp_time=0, alarm=0, prescaler=0; with alarm 00:00, no trigger occurs before 24 h of ticks.
